// File: rtl/xbus_sdram_pkg.sv
// xbus_sdram_pkg: shared types and constants for the xbus -> SDRAM command port.
//   xbus_state_e  : port FSM state encoding
//   XBUS_ADDR_W   : default word address width (xbus physical RAM space)
//   XBUS_DATA_W   : default data word width
//   TIMEOUT_RDATA : read data returned when the memory never answers
package xbus_sdram_pkg;

  localparam int unsigned XBUS_ADDR_W = 22;
  localparam int unsigned XBUS_DATA_W = 32;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } xbus_state_e;

endpackage

// File: rtl/xbus_sdram_rdcache.sv
// xbus_sdram_rdcache: one-entry read buffer (valid, tag, data) in front of the SDRAM port.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset (invalidates the entry)
//   fill_en/addr/data   : load the entry from a completed memory read
//   wr_en/addr/data     : write-through; updates data only when the tag matches
//   inval               : drop the entry (timeout)
//   lookup_addr         : address to test for a hit
//   hit_c, hit_data_c   : combinational hit flag and buffered data
module xbus_sdram_rdcache
  import xbus_sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = XBUS_ADDR_W,
  parameter int unsigned DATA_W = XBUS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit_c,
  output logic [DATA_W-1:0] hit_data_c
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q,   tag_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Entry update: invalidate beats fill, fill beats write-through.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inval) begin
      valid_d = 1'b0;
    end else if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_addr;
      data_d  = fill_data;
    end else if (wr_en && valid_q && (tag_q == wr_addr)) begin
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_c      = valid_q && (tag_q == lookup_addr);
  assign hit_data_c = data_q;

endmodule

// File: rtl/xbus_sdram_port.sv
// xbus_sdram_port: converts the xbus RAM decoder's level-held read/write request into a
// single valid/accept command on the SDRAM controller port, returns 1-cycle rd_ready /
// wr_done pulses, and forces completion after TIMEOUT cycles (0 disables the timeout).
// Optional feature: define XBUS_SDRAM_RDCACHE_EN to add a one-entry read buffer.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   req_rd, req_wr, req_addr, req_wdata : xbus side request (held until acknowledged)
//   rd_data, rd_ready, wr_done        : completion back to xbus
//   timeout_err                       : sticky timeout flag, cleared only by reset
//   mem_valid, mem_we, mem_addr, mem_wdata, mem_accept : SDRAM command handshake
//   mem_rvalid, mem_rdata             : SDRAM read return
module xbus_sdram_port
  import xbus_sdram_pkg::*;
#(
  parameter int unsigned ADDR_W  = XBUS_ADDR_W,
  parameter int unsigned DATA_W  = XBUS_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ready,
  output logic              wr_done,
  output logic              timeout_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_accept,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter only needs to hold 0..TIMEOUT-1; the timeout fires as it would reach TIMEOUT.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  xbus_state_e       state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_ready_q, rd_ready_d;
  logic              wr_done_q, wr_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy_c;
  logic              xfer_c;
  logic              done_c;
  logic              rdata_take_c;
  logic              tmo_hit_c;
  logic              tmo_c;
  logic              rd_hit_c;
  logic [DATA_W-1:0] cache_data_c;

  assign busy_c = (state_q == ISSUE) || (state_q == WAIT_RD);
  assign xfer_c = mem_valid_q && mem_accept;

  // Read data is legal in the accept cycle as well as in WAIT_RD; elsewhere it is stale.
  assign rdata_take_c = ((state_q == ISSUE) && xfer_c && !mem_we_q && mem_rvalid) ||
                        ((state_q == WAIT_RD) && mem_rvalid);
  assign done_c       = ((state_q == ISSUE) && xfer_c && mem_we_q) || rdata_take_c;

  // A real completion on the timeout edge wins over the timeout.
  assign tmo_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign tmo_c     = busy_c && tmo_hit_c && !done_c;

`ifdef XBUS_SDRAM_RDCACHE_EN
  logic cache_hit_c;

  xbus_sdram_rdcache #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rdcache (
    .clk         (clk),
    .reset       (reset),
    .fill_en     (rdata_take_c),
    .fill_addr   (mem_addr_q),
    .fill_data   (mem_rdata),
    .wr_en       (xfer_c && mem_we_q),
    .wr_addr     (mem_addr_q),
    .wr_data     (mem_wdata_q),
    .inval       (tmo_c),
    .lookup_addr (req_addr),
    .hit_c       (cache_hit_c),
    .hit_data_c  (cache_data_c)
  );

  // Writes take priority, so a simultaneous read/write never hits.
  assign rd_hit_c = req_rd && !req_wr && cache_hit_c;
`else
  assign rd_hit_c     = 1'b0;
  assign cache_data_c = '0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_data_q     <= '0;
      rd_ready_q    <= 1'b0;
      wr_done_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_valid_q   <= mem_valid_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_data_q     <= rd_data_d;
      rd_ready_q    <= rd_ready_d;
      wr_done_q     <= wr_done_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_wr || req_rd) begin
          state_d = rd_hit_c ? ACK : ISSUE;
        end
      end
      ISSUE: begin
        if (done_c || tmo_c) begin
          state_d = ACK;
        end else if (xfer_c) begin
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (done_c || tmo_c) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_rd && !req_wr) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rd_data_d     = rd_data_q;
    rd_ready_d    = 1'b0;
    wr_done_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_wr || req_rd) begin
          mem_we_d    = req_wr;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          cnt_d       = '0;
          mem_valid_d = !rd_hit_c;
          if (rd_hit_c) begin
            rd_data_d = cache_data_c;
          end
        end
      end
      ISSUE, WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (xfer_c || tmo_c) begin
          mem_valid_d = 1'b0;
        end
        if (rdata_take_c) begin
          rd_data_d = mem_rdata;
        end
        if (tmo_c) begin
          timeout_err_d = 1'b1;
          if (!mem_we_q) begin
            rd_data_d = DATA_W'(TIMEOUT_RDATA);
          end
        end
      end
      ACK: begin
        // mem_we_q still records which kind of transaction is finishing.
        rd_ready_d = !mem_we_q;
        wr_done_d  = mem_we_q;
      end
      default: begin
      end
    endcase
  end

  assign rd_data     = rd_data_q;
  assign rd_ready    = rd_ready_q;
  assign wr_done     = wr_done_q;
  assign timeout_err = timeout_err_q;
  assign mem_valid   = mem_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
